// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR sequencer: op codes, CSR addresses,
// mstatus bit positions and FSM state encodings.
package csr_pkg;

  typedef enum logic [2:0] {
    CSR_RW    = 3'd0,
    CSR_RS    = 3'd1,
    CSR_RC    = 3'd2,
    CSR_ECALL = 3'd3,
    CSR_MRET  = 3'd4
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RMW     = 4'd1;
  localparam logic [3:0] ST_T_EPC   = 4'd2;
  localparam logic [3:0] ST_T_CAUSE = 4'd3;
  localparam logic [3:0] ST_T_STAT  = 4'd4;
  localparam logic [3:0] ST_T_VEC   = 4'd5;
  localparam logic [3:0] ST_R_STAT  = 4'd6;
  localparam logic [3:0] ST_R_EPC   = 4'd7;
  localparam logic [3:0] ST_RESP    = 4'd8;

endpackage

// File: rtl/csr_seq_ctrl_if.sv
// Request, CSR-port and response signals of the CSR sequencer.
interface csr_seq_ctrl_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [11:0]      in_addr;
  logic [WIDTH-1:0] in_src;
  logic             in_src_zero;
  logic [WIDTH-1:0] in_pc;
  logic [11:0]      csr_addr;
  logic             csr_wen;
  logic [WIDTH-1:0] csr_wdata;
  logic [WIDTH-1:0] csr_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_rd_data;
  logic             out_redirect;
  logic [WIDTH-1:0] out_redirect_pc;

  modport slave (
    input  in_valid, in_op, in_addr, in_src, in_src_zero, in_pc,
    output in_ready,
    output csr_addr, csr_wen, csr_wdata,
    input  csr_rdata,
    output out_valid, out_rd_data, out_redirect, out_redirect_pc,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_addr, in_src, in_src_zero, in_pc,
    input  in_ready,
    input  csr_addr, csr_wen, csr_wdata,
    output csr_rdata,
    input  out_valid, out_rd_data, out_redirect, out_redirect_pc,
    output out_ready
  );
endinterface

// File: rtl/csr_rmw_alu.sv
// Combinational new-value function: RW/RS/RC on any CSR, and the mstatus
// trap-entry (ECALL) / trap-return (MRET) update.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] src,
  input  logic             src_zero,
  output logic [WIDTH-1:0] new_val,
  output logic             wr_sup
);

  always_comb begin
    new_val = old_val;
    wr_sup  = 1'b0;
    case (op)
      CSR_RW: new_val = src;
      CSR_RS: begin
        new_val = old_val | src;
        wr_sup  = src_zero;
      end
      CSR_RC: begin
        new_val = old_val & ~src;
        wr_sup  = src_zero;
      end
      CSR_ECALL: begin
        new_val[MSTATUS_MPIE]                  = old_val[MSTATUS_MIE];
        new_val[MSTATUS_MIE]                   = 1'b0;
        new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MRET: begin
        new_val[MSTATUS_MIE]                   = old_val[MSTATUS_MPIE];
        new_val[MSTATUS_MPIE]                  = 1'b1;
        new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_seq_ctrl.sv
// Sequencer owning the single CSR-file port: runs CSR read-modify-write,
// ECALL trap entry and MRET return, then presents rd value and PC redirect.
module csr_seq_ctrl
  import csr_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CAUSE_ECALL = 11
) (
  input  logic            clk,
  input  logic            rst,
  csr_seq_ctrl_if.slave   bus
);

  logic [3:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [11:0]      addr_q, addr_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic             src_zero_q, src_zero_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic [11:0]      csr_addr_c;
  logic             csr_wen_c;
  logic [WIDTH-1:0] csr_wdata_c;
  logic [WIDTH-1:0] alu_new;
  logic             alu_sup;

  csr_rmw_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (op_q),
    .old_val  (bus.csr_rdata),
    .src      (src_q),
    .src_zero (src_zero_q),
    .new_val  (alu_new),
    .wr_sup   (alu_sup)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    src_d         = src_q;
    src_zero_d    = src_zero_q;
    pc_d          = pc_q;
    rd_data_d     = rd_data_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    csr_addr_c    = '0;
    csr_wen_c     = 1'b0;
    csr_wdata_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d          = bus.in_op;
          addr_d        = bus.in_addr;
          src_d         = bus.in_src;
          src_zero_d    = bus.in_src_zero;
          pc_d          = bus.in_pc;
          rd_data_d     = '0;
          redirect_d    = 1'b0;
          redirect_pc_d = '0;
          case (bus.in_op)
            CSR_RW, CSR_RS, CSR_RC: state_d = ST_RMW;
            CSR_ECALL:              state_d = ST_T_EPC;
            CSR_MRET:               state_d = ST_R_STAT;
            default:                state_d = ST_RESP;
          endcase
        end
      end
      ST_RMW: begin
        csr_addr_c  = addr_q;
        csr_wdata_c = alu_new;
        csr_wen_c   = !alu_sup;
        rd_data_d   = bus.csr_rdata;
        state_d     = ST_RESP;
      end
      ST_T_EPC: begin
        csr_addr_c  = CSR_MEPC;
        csr_wdata_c = pc_q;
        csr_wen_c   = 1'b1;
        state_d     = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_addr_c  = CSR_MCAUSE;
        csr_wdata_c = WIDTH'(CAUSE_ECALL);
        csr_wen_c   = 1'b1;
        state_d     = ST_T_STAT;
      end
      ST_T_STAT: begin
        csr_addr_c  = CSR_MSTATUS;
        csr_wdata_c = alu_new;
        csr_wen_c   = 1'b1;
        state_d     = ST_T_VEC;
      end
      ST_T_VEC: begin
        // mtvec low bits are the mode field, not part of the target
        csr_addr_c    = CSR_MTVEC;
        redirect_pc_d = {bus.csr_rdata[WIDTH-1:2], 2'b00};
        redirect_d    = 1'b1;
        state_d       = ST_RESP;
      end
      ST_R_STAT: begin
        csr_addr_c  = CSR_MSTATUS;
        csr_wdata_c = alu_new;
        csr_wen_c   = 1'b1;
        state_d     = ST_R_EPC;
      end
      ST_R_EPC: begin
        csr_addr_c    = CSR_MEPC;
        redirect_pc_d = bus.csr_rdata;
        redirect_d    = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      src_q         <= '0;
      src_zero_q    <= 1'b0;
      pc_q          <= '0;
      rd_data_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      src_q         <= src_d;
      src_zero_q    <= src_zero_d;
      pc_q          <= pc_d;
      rd_data_q     <= rd_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.in_ready        = (state_q == ST_IDLE);
  assign bus.out_valid       = (state_q == ST_RESP);
  assign bus.out_rd_data     = rd_data_q;
  assign bus.out_redirect    = redirect_q;
  assign bus.out_redirect_pc = redirect_pc_q;
  assign bus.csr_addr        = csr_addr_c;
  assign bus.csr_wdata       = csr_wdata_c;
  // A write in flight on a reset edge is abandoned rather than committed.
  assign bus.csr_wen         = csr_wen_c & rst;

endmodule

// File: doc/csr_seq_ctrl.md
Name: csr_seq_ctrl

Overview:
Multi-cycle sequencer that owns the single read/write port of the machine-mode CSR file (mcause, mstatus, mtvec, mepc). It accepts one CSR-class instruction at a time from execute over a valid/ready handshake. Supported instructions are CSRRW, CSRRS, CSRRC, ECALL and MRET. It performs the read-modify-write or trap-entry/return register sequence through the one port, then returns the rd value and any PC redirect to writeback/fetch over a second valid/ready handshake.

Parameters:
WIDTH, 32, data/PC width
CAUSE_ECALL, 11, mcause value written on ECALL from M-mode

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low: state cleared on a rising clk edge while rst==0
in_valid  in  1  request valid
in_ready  out  1  controller can accept a request
in_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET; 5-7 reserved
in_addr  in  12  CSR address
in_src  in  WIDTH  rs1 value or zero-extended zimm
in_src_zero  in  1  rs1/zimm field is x0/0
in_pc  in  WIDTH  PC of the instruction
csr_addr  out  12  CSR file address
csr_wen  out  1  CSR file write enable
csr_wdata  out  WIDTH  CSR file write data
csr_rdata  in  WIDTH  CSR file combinational read data for csr_addr
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_rd_data  out  WIDTH  old CSR value for rd; 0 for ECALL/MRET
out_redirect  out  1  fetch must jump to out_redirect_pc
out_redirect_pc  out  WIDTH  target PC

Behaviour:
- States: IDLE, RMW, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC, RESP.
- Request latching: in_ready=1 only in IDLE. On in_valid&in_ready, latch op/addr/src/src_zero/pc and go to:
  - RMW for ops 0-2
  - T_EPC for op 3
  - R_STAT for op 4
  - RESP for ops 5-7, with out_rd_data=0 and out_redirect=0
- RMW (1 cycle):
  - csr_addr=addr. Latch csr_rdata as old value.
  - New value by op: RW=src; RS=old|src; RC=old&~src.
  - csr_wen=1, except RS/RC with src_zero=1 (no write). RW always writes.
  - Next state: RESP.
- ECALL sequence:
  - T_EPC: write 0x341 <= pc.
  - T_CAUSE: write 0x342 <= CAUSE_ECALL.
  - T_STAT: read 0x300. Write with MPIE(bit7)=old MIE(bit3), MIE=0, MPP[12:11]=2'b11, other bits unchanged.
  - T_VEC: read 0x305, no write. redirect_pc = rdata & ~3.
  - Then RESP with redirect=1.
- MRET sequence:
  - R_STAT: read 0x300. Write with MIE=old MPIE, MPIE=1, MPP=2'b11.
  - R_EPC: read 0x341, no write. redirect_pc = rdata.
  - Then RESP with redirect=1.
- RESP: out_valid=1 with outputs held stable until out_valid&out_ready, then IDLE. Back-to-back requests: the next acceptance occurs at the earliest in the cycle after the handshake.
- Latency from the acceptance edge to the first cycle of out_valid: CSR ops 2 cycles, ECALL 5, MRET 3, reserved 1.
- Outside the write states, csr_wen=0. csr_addr=0 and csr_wdata=0 when idle.
- Reset (rst==0 at an edge, in any state including mid-sequence):
  - state=IDLE
  - all latched registers 0
  - out_valid=0, out_redirect=0, out_rd_data=0, out_redirect_pc=0, csr_wen=0
  - the in-flight request is dropped; partial trap writes already committed stay.
- Once accepted, a request always completes; there is no flush or kill input.
- in_op/in_addr are ignored while in_valid=0.

Decomposition:
- Shared package csr_pkg:
  - op enum (CSR_RW, CSR_RS, CSR_RC, CSR_ECALL, CSR_MRET)
  - CSR address constants (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342)
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11)
  - state enum
- One natural sub-module, csr_rmw_alu: the combinational RW/RS/RC/mstatus-update function with a write-suppress flag, instantiated by the FSM.

Test Plan:
- Reset then CSRRW addr 0x305 src 0x80000100, CSR holds 0 -> one write of 0x80000100 to 0x305; out_rd_data=0 at T+2; out_redirect=0.
- CSRRS 0x300 src 0x8 with mstatus=0x1800 -> write 0x1808, rd=0x1800. Repeat with src_zero=1 -> csr_wen never asserted, rd=0x1808.
- ECALL pc=0x80000040, mtvec=0x80000103, mstatus=0x1808:
  - writes in order: mepc=0x80000040, mcause=11, mstatus=0x1880
  - out_valid at T+5, redirect_pc=0x80000100.
- MRET with mepc=0x80000044, mstatus=0x1880 -> mstatus write 0x1888; redirect_pc=0x80000044 at T+3.
- out_ready held 0 for 4 cycles in RESP -> outputs stable, in_ready=0; request accepted the cycle after out_ready=1.
- rst=0 asserted during T_CAUSE -> next cycle IDLE with all outputs 0; mepc already written, mcause unchanged.
